// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle HI/LO multiply/divide unit (shift-add / restoring).
//            `define MULDIV_FAST_MUL_EN for single-cycle MULT/MULTU.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] Rdata1,
    input  logic [XLEN-1:0] Rdata2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    localparam int         CW      = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic                dz_q, dz_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     araw_q, araw_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                done_q, done_d;

    logic                w_signed, w_mul_op, w_div_op;
    logic                w_a_neg, w_b_neg;
    logic [XLEN-1:0]     w_a_mag, w_b_mag;
    logic [XLEN:0]       w_sum, w_trial;
    logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix, w_rem_fix;

    assign w_signed = (funct == F_MULT) || (funct == F_DIV);
    assign w_mul_op = (funct == F_MULT) || (funct == F_MULTU);
    assign w_div_op = (funct == F_DIV)  || (funct == F_DIVU);
    assign w_a_neg  = w_signed & Rdata1[XLEN-1];
    assign w_b_neg  = w_signed & Rdata2[XLEN-1];
    assign w_a_mag  = w_a_neg ? -Rdata1 : Rdata1;
    assign w_b_mag  = w_b_neg ? -Rdata2 : Rdata2;

    // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
    assign w_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
    assign w_mul_next = {w_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left one bit per step.
    assign w_trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    assign w_div_next = w_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                      : {w_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign w_prod_fix = neg_q  ? -acc_q : acc_q;
    assign w_quo_fix  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign w_rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_a, w_fast_b, w_fast_p;
    assign w_fast_a = {{XLEN{w_a_neg}}, Rdata1};
    assign w_fast_b = {{XLEN{w_b_neg}}, Rdata2};
    assign w_fast_p = w_fast_a * w_fast_b;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        acc_d    = acc_q;
        b_d      = b_q;
        araw_d   = araw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (funct == F_MTHI) begin
                        hi_d = Rdata1;
                    end else if (funct == F_MTLO) begin
                        lo_d = Rdata1;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (w_mul_op) begin
                        hi_d   = w_fast_p[2*XLEN-1:XLEN];
                        lo_d   = w_fast_p[XLEN-1:0];
                        done_d = 1'b1;
`endif
                    end else if (w_mul_op || w_div_op) begin
                        state_d  = S_RUN;
                        cnt_d    = '0;
                        is_div_d = w_div_op;
                        neg_d    = w_a_neg ^ w_b_neg;
                        rneg_d   = w_a_neg;
                        dz_d     = w_div_op && (Rdata2 == '0);
                        araw_d   = Rdata1;
                        if (w_div_op) begin
                            acc_d = {{XLEN{1'b0}}, w_a_mag};
                            b_d   = w_b_mag;
                        end else begin
                            acc_d = {{XLEN{1'b0}}, w_b_mag};
                            b_d   = w_a_mag;
                        end
                    end
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? w_div_next : w_mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = w_prod_fix[2*XLEN-1:XLEN];
                    lo_d = w_prod_fix[XLEN-1:0];
                end else if (dz_q) begin
                    hi_d = araw_q;
                    lo_d = {XLEN{1'b1}};
                end else begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            acc_q    <= '0;
            b_q      <= '0;
            araw_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            araw_q   <= araw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit (HI/LO results, latency, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_BUSY = 33;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] Rdata1, Rdata2;
    logic        busy, done;
    logic [31:0] HI, LO;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic        saw_act;

    muldiv_unit #(.XLEN(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .funct(funct),
        .Rdata1(Rdata1), .Rdata2(Rdata2),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain SV arithmetic, independent of the iterative datapath.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic signed [31:0] q, r;
        case (f)
            F_MULT: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p;
            end
            F_MULTU: return {32'd0, a} * {32'd0, b};
            F_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge CLK) begin
        if (RST) begin
            if (busy || done) saw_act = 1'b1;
            if (done) begin
                check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("HI", {32'd0, HI}, {32'd0, e[63:32]});
                    check_val("LO", {32'd0, LO}, {32'd0, e[31:0]});
                end
            end
        end
    end

    // Called and returns at #1 after a rising edge; issue is sampled at the next edge.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_busy, input int poke_at);
        int cyc;
        int busy_cyc;
        funct  = f;
        Rdata1 = a;
        Rdata2 = b;
        start  = 1'b1;
        exp_q.push_back(exp);
        @(posedge CLK); #1;
        start  = 1'b0;
        Rdata1 = $urandom;
        Rdata2 = $urandom;
        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cyc++;
            if (cyc == poke_at) begin
                start = 1'b1; funct = F_DIVU; Rdata1 = 32'd77; Rdata2 = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        start = 1'b0;
        check_val("done_seen", 64'(done), 64'd1);
        check_val("busy_cycles", 64'(busy_cyc), 64'(exp_busy));
    endtask

    task automatic move_to(input logic [5:0] f, input logic [31:0] a);
        funct  = f;
        Rdata1 = a;
        start  = 1'b1;
        @(posedge CLK); #1;
        start  = 1'b0;
    endtask

    initial begin
        logic [5:0]  ops [4];
        logic [5:0]  f;
        logic [31:0] a, b;
        ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

        RST = 1'b0; start = 1'b0; funct = 6'd0; Rdata1 = '0; Rdata2 = '0;
        saw_act = 1'b0;
        #2;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_HI", {32'd0, HI}, 64'd0);
        check_val("rst_LO", {32'd0, LO}, 64'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;

        // MTHI/MTLO on consecutive cycles; no handshake activity expected
        saw_act = 1'b0;
        move_to(F_MTHI, 32'h12345678);
        move_to(F_MTLO, 32'h9ABCDEF0);
        @(posedge CLK); #1;
        check_val("mthi", {32'd0, HI}, 64'h12345678);
        check_val("mtlo", {32'd0, LO}, 64'h9ABCDEF0);
        check_val("mt_no_handshake", 64'(saw_act), 64'd0);

        run_op(F_MULT,  32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, MUL_BUSY, -1);
        run_op(F_MULTU, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, MUL_BUSY, -1);
        run_op(F_DIV,   32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, -1);
        run_op(F_DIVU,  32'd100, 32'd7, {32'd2, 32'd14}, 33, -1);
        run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, -1);
        run_op(F_DIVU,  32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 33, 10);
        run_op(F_DIV,   32'hFFFFFFF0, 32'd0, {32'hFFFFFFF0, 32'hFFFFFFFF}, 33, -1);
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, MUL_BUSY, -1);

        for (int i = 0; i < 8; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = (i < 4) ? $urandom : 32'($urandom_range(0, 1000));
            b = (i[0]) ? $urandom : -32'($urandom_range(1, 50));
            run_op(f, a, b, model(f, a, b),
                   (f == F_MULT || f == F_MULTU) ? MUL_BUSY : 33, -1);
        end

        // Asynchronous reset in the middle of an iterative operation
`ifdef MULDIV_FAST_MUL_EN
        funct = F_DIVU;
`else
        funct = F_MULT;
`endif
        Rdata1 = 32'h00001234; Rdata2 = 32'h00005678; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        check_val("abort_HI", {32'd0, HI}, 64'd0);
        check_val("abort_LO", {32'd0, LO}, 64'd0);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1;
        run_op(F_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 33, -1);

        @(posedge CLK); #1;
        check_val("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
